// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back select, 32x32 register file and retired-write counter.
// Define WB_RF_BYPASS_EN to forward the value being written back to same-cycle reads.
module wb_regfile #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 2**AW,
    parameter int CW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RegWr_in,
    input  logic          RegDst_in,
    input  logic          MemToReg_in,
    input  logic [AW-1:0] rt_in,
    input  logic [AW-1:0] rd_in,
    input  logic [DW-1:0] Dout_in,
    input  logic [DW-1:0] Result_in,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    output logic          wb_we,
    output logic [AW-1:0] wb_dst,
    output logic [DW-1:0] wb_data,
    output logic [CW-1:0] wr_count
);
    logic [DW-1:0] regs_q [NREG];
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wb_dst   = RegDst_in ? rd_in : rt_in;
        wb_data  = MemToReg_in ? Dout_in : Result_in;
        wb_we    = RegWr_in && (wb_dst != '0);
        cnt_d    = cnt_q + CW'(wb_we);
        wr_count = cnt_q;
    end

    // reads are forced to 0 during reset so a bypassed wb_data never leaks out
    always_comb begin
`ifdef WB_RF_BYPASS_EN
        ra_data = (!rst_n || ra_addr == '0) ? '0 : (wb_we && ra_addr == wb_dst) ? wb_data : regs_q[ra_addr];
        rb_data = (!rst_n || rb_addr == '0) ? '0 : (wb_we && rb_addr == wb_dst) ? wb_data : regs_q[rb_addr];
`else
        ra_data = (!rst_n || ra_addr == '0) ? '0 : regs_q[ra_addr];
        rb_data = (!rst_n || rb_addr == '0) ? '0 : regs_q[rb_addr];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            cnt_q <= '0;
        end else if (wb_we) begin
            regs_q[wb_dst] <= wb_data;
            cnt_q          <= cnt_d;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector table plus hand-written reset, hazard, bubble and wrap sequences.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWr_in, RegDst_in, MemToReg_in;
    logic [4:0]  rt_in, rd_in, ra_addr, rb_addr, wb_dst;
    logic [31:0] Dout_in, Result_in, ra_data, rb_data, wb_data;
    logic        wb_we;
    logic [3:0]  wr_count;
    int n_cmp = 0;
    int n_bad = 0;

    wb_regfile #(.DW(32), .AW(5), .NREG(32), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .RegWr_in(RegWr_in), .RegDst_in(RegDst_in),
        .MemToReg_in(MemToReg_in), .rt_in(rt_in), .rd_in(rd_in), .Dout_in(Dout_in),
        .Result_in(Result_in), .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data),
        .rb_data(rb_data), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        regwr, regdst, mtr;
        logic [4:0]  rt, rd;
        logic [31:0] dout, res;
        logic        we;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [3:0]  cnt;
        logic [31:0] rb;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        RegWr_in = 1'b0; RegDst_in = 1'b0; MemToReg_in = 1'b0;
        rt_in = '0; rd_in = '0; Dout_in = '0; Result_in = '0;
    endtask

    task automatic do_write(input logic [4:0] r, input logic [31:0] v);
        RegWr_in = 1'b1; RegDst_in = 1'b1; MemToReg_in = 1'b0; rd_in = r; Result_in = v;
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd5,  32'h0,        32'h1234,     1'b1, 5'd5,  32'h1234,     4'd1, 32'h1234};
        vt[1] = '{1'b1, 1'b0, 1'b1, 5'd7, 5'd2,  32'hDEADBEEF, 32'h11,       1'b1, 5'd7,  32'hDEADBEEF, 4'd2, 32'hDEADBEEF};
        vt[2] = '{1'b1, 1'b1, 1'b0, 5'd4, 5'd0,  32'h0,        32'hFFFFFFFF, 1'b0, 5'd0,  32'hFFFFFFFF, 4'd2, 32'h0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd3,  32'h0,        32'h55,       1'b0, 5'd3,  32'h55,       4'd2, 32'h0};
        vt[4] = '{1'b1, 1'b0, 1'b0, 5'd9, 5'd1,  32'h0,        32'h1,        1'b1, 5'd9,  32'h1,        4'd3, 32'h1};
        vt[5] = '{1'b1, 1'b0, 1'b1, 5'd0, 5'd9,  32'hCAFE,     32'h7,        1'b0, 5'd0,  32'hCAFE,     4'd3, 32'h0};
        vt[6] = '{1'b1, 1'b1, 1'b1, 5'd2, 5'd31, 32'h80000000, 32'h3,        1'b1, 5'd31, 32'h80000000, 4'd4, 32'h80000000};

        rst_n = 1'b0; idle(); ra_addr = 5'd5; rb_addr = 5'd31;
        #3;
        chk("reset_cnt", 32'(wr_count), 32'h0);
        chk("reset_ra", ra_data, 32'h0);
        chk("reset_we", 32'(wb_we), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            RegWr_in = vt[i].regwr; RegDst_in = vt[i].regdst; MemToReg_in = vt[i].mtr;
            rt_in = vt[i].rt; rd_in = vt[i].rd; Dout_in = vt[i].dout; Result_in = vt[i].res;
            ra_addr = '0; rb_addr = '0;
            #1;
            chk($sformatf("v%0d_we", i), 32'(wb_we), 32'(vt[i].we));
            chk($sformatf("v%0d_dst", i), 32'(wb_dst), 32'(vt[i].dst));
            chk($sformatf("v%0d_data", i), wb_data, vt[i].data);
            @(posedge clk); #1;
            idle(); ra_addr = vt[i].dst; rb_addr = vt[i].dst;
            #1;
            chk($sformatf("v%0d_ra", i), ra_data, vt[i].rb);
            chk($sformatf("v%0d_rb", i), rb_data, vt[i].rb);
            chk($sformatf("v%0d_cnt", i), 32'(wr_count), 32'(vt[i].cnt));
        end

        // same-cycle write/read of r9 (currently 1)
        RegWr_in = 1'b1; RegDst_in = 1'b0; MemToReg_in = 1'b0; rt_in = 5'd9; Result_in = 32'hA5A5A5A5;
        ra_addr = 5'd9; rb_addr = 5'd9;
        #1;
`ifdef WB_RF_BYPASS_EN
        chk("haz_ra_same", ra_data, 32'hA5A5A5A5);
        chk("haz_rb_same", rb_data, 32'hA5A5A5A5);
`else
        chk("haz_ra_same", ra_data, 32'h1);
        chk("haz_rb_same", rb_data, 32'h1);
`endif
        @(posedge clk); #1; idle(); #1;
        chk("haz_ra_next", ra_data, 32'hA5A5A5A5);
        chk("haz_rb_next", rb_data, 32'hA5A5A5A5);
        chk("haz_cnt", 32'(wr_count), 32'h5);

        RegWr_in = 1'b0; RegDst_in = 1'b1; rd_in = 5'd3; Result_in = 32'h55; ra_addr = 5'd3;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bub%0d_we", c), 32'(wb_we), 32'h0);
            chk($sformatf("bub%0d_dst", c), 32'(wb_dst), 32'h3);
            chk($sformatf("bub%0d_data", c), wb_data, 32'h55);
            @(posedge clk); #1;
        end
        chk("bub_reg3", ra_data, 32'h0);
        chk("bub_cnt", 32'(wr_count), 32'h5);
        idle();

        for (int r = 1; r < 32; r++) do_write(5'(r), 32'h01010101 * r);
        ra_addr = 5'd17; #1;
        chk("fill_r17", ra_data, 32'h11111111);
        chk("fill_cnt", 32'(wr_count), 32'h4);

        // async reset mid-cycle while a write is pending
        RegWr_in = 1'b1; RegDst_in = 1'b1; rd_in = 5'd5; Result_in = 32'hBAD;
        ra_addr = 5'd5; rb_addr = 5'd31;
        @(posedge clk); #2; rst_n = 1'b0; #1;
        chk("arst_cnt", 32'(wr_count), 32'h0);
        chk("arst_ra", ra_data, 32'h0);
        chk("arst_rb", rb_data, 32'h0);
        RegWr_in = 1'bx; RegDst_in = 1'bx; rd_in = 'x;
        @(posedge clk); #1;
        chk("arst_hold_cnt", 32'(wr_count), 32'h0);
        @(negedge clk); idle(); rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            ra_addr = 5'(r); rb_addr = 5'(31 - r); #1;
            chk($sformatf("arst_r%0d", r), ra_data, 32'h0);
        end
        chk("arst_rb0", rb_data, 32'h0);

        for (int k = 0; k < 17; k++) do_write(5'(k + 1), 32'h100 + k);
        chk("wrap_cnt", 32'(wr_count), 32'h1);
        for (int r = 1; r < 32; r++) begin
            ra_addr = 5'(r); #1;
            chk($sformatf("wrap_r%0d", r), ra_data, r <= 17 ? 32'h100 + r - 1 : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
